// File: rtl/countdown_if.sv
// Countdown core control/display bundle.
//   load        : one-cycle pulse, capture load_bcd as the new preset
//   load_bcd    : preset {mm_t, mm_o, ss_t, ss_o}, 4-bit BCD each
//   start_stop  : one-cycle pulse, toggle run/pause
//   clear       : one-cycle pulse, return to idle
//   bcd         : code of the currently scanned digit (11 = dash)
//   an          : active-low one-hot digit enable, an[0] = ss_o, an[3] = mm_t
//   running     : high only while counting down
//   done        : high only after reaching 00:00
// master drives the controls; slave is the core.
interface countdown_if;
  logic        load;
  logic [15:0] load_bcd;
  logic        start_stop;
  logic        clear;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        running;
  logic        done;

  modport master (
    output load, load_bcd, start_stop, clear,
    input  bcd, an, running, done
  );

  modport slave (
    input  load, load_bcd, start_stop, clear,
    output bcd, an, running, done
  );
endinterface

// File: rtl/countdown_core.sv
// MM:SS countdown timer with a multiplexed 4-digit BCD display driver.
//   clk   : system clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : countdown_if.slave (load/load_bcd/start_stop/clear in,
//           bcd/an/running/done out, all outputs registered)
// TICK_DIV clock cycles make one countdown second; SCAN_DIV cycles per digit slot.
module countdown_core #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned SCAN_DIV = 100000
) (
  input logic       clk,
  input logic       rst_n,
  countdown_if.slave bus
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);
  localparam logic [3:0] DashCode = 4'd11;

  typedef enum logic [1:0] {StIdle, StPaused, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      digits_q, digits_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [ScanW-1:0] scan_q, scan_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  logic             preset_ok;
  logic [15:0]      dec_val;

  // One-second decrement with BCD borrow chain: ss_o 0-9, ss_t 0-5, mm_o 0-9, mm_t 0-9.
  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [3:0] ss_o, ss_t, mm_o, mm_t;
    ss_o = t[3:0];
    ss_t = t[7:4];
    mm_o = t[11:8];
    mm_t = t[15:12];
    if (ss_o != 4'd0) begin
      ss_o = ss_o - 4'd1;
    end else begin
      ss_o = 4'd9;
      if (ss_t != 4'd0) begin
        ss_t = ss_t - 4'd1;
      end else begin
        ss_t = 4'd5;
        if (mm_o != 4'd0) begin
          mm_o = mm_o - 4'd1;
        end else begin
          mm_o = 4'd9;
          mm_t = mm_t - 4'd1;
        end
      end
    end
    return {mm_t, mm_o, ss_t, ss_o};
  endfunction

  assign preset_ok = (bus.load_bcd[15:12] <= 4'd9) && (bus.load_bcd[11:8] <= 4'd9) &&
                     (bus.load_bcd[7:4] <= 4'd5) && (bus.load_bcd[3:0] <= 4'd9);
  assign dec_val   = dec_time(digits_q);

  // Time-keeping FSM. An invalid load still consumes the cycle: nothing changes,
  // not even the run-time tick counter, and any start_stop alongside it is dropped.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    tick_d   = tick_q;
    if (bus.clear) begin
      state_d  = StIdle;
      digits_d = 16'h0000;
      tick_d   = '0;
    end else if (bus.load) begin
      if (preset_ok) begin
        state_d  = StPaused;
        digits_d = bus.load_bcd;
        tick_d   = '0;
      end
    end else begin
      unique case (state_q)
        StPaused: begin
          if (bus.start_stop && (digits_q != 16'h0000)) state_d = StRun;
        end
        StRun: begin
          if (bus.start_stop) begin
            state_d = StPaused;
          end else if (tick_q == TickMax) begin
            tick_d   = '0;
            digits_d = dec_val;
            if (dec_val == 16'h0000) state_d = StDone;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Display scan and registered outputs. an and bcd are both computed from the
  // next-state index/digits so the pair always updates on the same edge.
  always_comb begin
    scan_d = scan_q + ScanW'(1);
    idx_d  = idx_q;
    if (scan_q == ScanMax) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    an_d      = ~(4'b0001 << idx_d);
    bcd_d     = (state_d == StIdle) ? DashCode : digits_d[{idx_d, 2'b00} +: 4];
    running_d = (state_d == StRun);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      digits_q  <= 16'h0000;
      tick_q    <= '0;
      scan_q    <= '0;
      idx_q     <= 2'd0;
      an_q      <= 4'b1110;
      bcd_q     <= DashCode;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      tick_q    <= tick_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.an      = an_q;
  assign bus.bcd     = bcd_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule
